// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding I-cache request at a time, responses queued as {pc, inst} toward decode.
// Cache hits push in the request cycle. Fetch stalls while the queue is full. A redirect flushes the queue and drops any late response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ic_addr,
  output logic        ic_send_pulse,
  input  logic [31:0] ic_inst,
  input  logic        ic_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  state_t          state, state_nxt;
  logic [31:0]     pc, pc_nxt;
  logic [31:0]     req_pc, req_pc_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   wptr, rptr;
  fq_entry_t       mem [QDEPTH];
  fq_entry_t       push_dat;
  logic            push, pop, send;

  assign dec_valid     = (count != '0);
  assign dec_pc        = mem[rptr].pc;
  assign dec_inst      = mem[rptr].inst;
  assign pop           = dec_valid & dec_ready & ~redirect;
  // Reset holds state at IDLE, so the request strobe must also be gated by rst.
  assign ic_send_pulse = send & ~rst;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    push       = 1'b0;
    push_dat   = '0;
    send       = 1'b0;
    ic_addr    = req_pc;
    count_nxt  = count;

    case (state)
      IDLE: begin
        ic_addr = pc;
        if (!redirect && count < FULL) begin
          send       = 1'b1;
          req_pc_nxt = pc;
          if (ic_ack) begin
            push     = 1'b1;
            push_dat = '{pc: pc, inst: ic_inst};
            pc_nxt   = pc + 32'd4;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (ic_ack) begin
          state_nxt = IDLE;
          if (!redirect) begin
            push     = 1'b1;
            push_dat = '{pc: req_pc, inst: ic_inst};
            pc_nxt   = req_pc + 32'd4;
          end
        end else if (redirect) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (ic_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect) begin
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      push      = 1'b0;
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
      count  <= count_nxt;
      if (redirect) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

endmodule
